ingame_turn_fsm: RTL and testbench

Sequences one tile-matching game while the mode controller reports in-game play. The block:
- moves a cursor over the tile grid and reads tile values from the board memory;
- compares two selected tiles, reveals matched pairs and shows a mismatch for a fixed time;
- counts pairs and moves;
- raises `gameOver` back to the mode controller when every pair is found.

It sits between the PS/2 keyboard interface, the board memory and the VGA renderer.

---
 rtl/game_pkg.sv | 34 +++
 rtl/ps2_key_decoder.sv | 56 +++++
 rtl/ingame_turn_fsm.sv | 229 ++++++++++++++++++++++
 tb/tb_ingame_turn_fsm.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the tile-matching game.
//   - PS/2 set-2 scan codes used by the in-game FSM and the mode controller
//   - state encoding of the in-game turn FSM
//   - state codes of the mode controller
package game_pkg;

  localparam logic [7:0] KeyBreak  = 8'hF0;
  localparam logic [7:0] KeyUp     = 8'h1D;  // W
  localparam logic [7:0] KeyDown   = 8'h1B;  // S
  localparam logic [7:0] KeyLeft   = 8'h1C;  // A
  localparam logic [7:0] KeyRight  = 8'h23;  // D
  localparam logic [7:0] KeySelect = 8'h29;  // space
  localparam logic [7:0] KeyEnter  = 8'h5A;  // mode controller only

  typedef enum logic [3:0] {
    StIdle,
    StSel1,
    StRd1,
    StCap1,
    StSel2,
    StRd2,
    StCap2,
    StCmp,
    StShow,
    StDone
  } turn_state_e;

  typedef enum logic [1:0] {
    ModeTitle    = 2'd0,
    ModeInGame   = 2'd1,
    ModeGameOver = 2'd2
  } mode_state_e;

endpackage

// File: rtl/ps2_key_decoder.sv
// Turns strobed PS/2 scan-code bytes into one-cycle movement/select pulses.
// A break prefix (F0) swallows the following byte so key releases never act.
// Decode is combinational on the strobe: pulses appear in the strobe cycle.
// Ports:
//   CLOCK_50         system clock
//   userquit         asynchronous active-high reset
//   clear            synchronous clear of the break flag; also masks pulses
//   ps2_key_data     scan-code byte
//   ps2_key_pressed  one-cycle strobe qualifying ps2_key_data
//   up/down/left/right/select  one-cycle decoded key pulses
module ps2_key_decoder
  import game_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       userquit,
  input  logic       clear,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       select
);

  logic break_q, break_d;
  logic make_valid;

  always_ff @(posedge CLOCK_50 or posedge userquit) begin
    if (userquit) begin
      break_q <= 1'b0;
    end else begin
      break_q <= break_d;
    end
  end

  always_comb begin
    break_d = break_q;
    if (clear) begin
      break_d = 1'b0;
    end else if (ps2_key_pressed) begin
      // The byte after F0 only clears the flag, even if it is F0 itself.
      break_d = break_q ? 1'b0 : (ps2_key_data == KeyBreak);
    end
  end

  always_comb begin
    make_valid = ps2_key_pressed && !break_q && !clear;
    up         = make_valid && (ps2_key_data == KeyUp);
    down       = make_valid && (ps2_key_data == KeyDown);
    left       = make_valid && (ps2_key_data == KeyLeft);
    right      = make_valid && (ps2_key_data == KeyRight);
    select     = make_valid && (ps2_key_data == KeySelect);
  end

endmodule

// File: rtl/ingame_turn_fsm.sv
// Runs one tile-matching game while the mode controller reports in-game play.
// Moves a cursor over the grid, reads two selected tiles from board memory,
// reveals matches, shows mismatches for SHOW_CYCLES clocks, counts pairs and
// moves, and raises gameOver once every pair is found.
// Ports:
//   CLOCK_50         system clock
//   userquit         asynchronous active-high reset
//   ingameOn         level; low returns everything to reset state next edge
//   ps2_key_data     scan-code byte
//   ps2_key_pressed  one-cycle strobe for ps2_key_data
//   tile_addr        board memory read address
//   tile_rd          one-cycle read strobe
//   tile_val         read data, valid the cycle after tile_rd
//   cursor           linear cursor index row*GRID_W+col
//   face_up          tiles drawn face up (matched or currently selected)
//   pairs_found      matched pair count
//   moves            completed two-tile attempts, saturating at 255
//   gameOver         high once all pairs are matched
module ingame_turn_fsm
  import game_pkg::*;
#(
  parameter int unsigned GRID_W      = 4,
  parameter int unsigned GRID_H      = 4,
  parameter int unsigned NUM_TILES   = GRID_W * GRID_H,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned VAL_W       = 3,
  parameter int unsigned SHOW_CYCLES = 25_000_000
) (
  input  logic                 CLOCK_50,
  input  logic                 userquit,
  input  logic                 ingameOn,
  input  logic [7:0]           ps2_key_data,
  input  logic                 ps2_key_pressed,
  output logic [ADDR_W-1:0]    tile_addr,
  output logic                 tile_rd,
  input  logic [VAL_W-1:0]     tile_val,
  output logic [ADDR_W-1:0]    cursor,
  output logic [NUM_TILES-1:0] face_up,
  output logic [ADDR_W-1:0]    pairs_found,
  output logic [7:0]           moves,
  output logic                 gameOver
);

  localparam int unsigned RowW   = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int unsigned ColW   = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int unsigned TimerW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  turn_state_e          state_q, state_d;
  logic [RowW-1:0]      row_q, row_d;
  logic [ColW-1:0]      col_q, col_d;
  logic [ADDR_W-1:0]    sel1_q, sel1_d;
  logic [ADDR_W-1:0]    sel2_q, sel2_d;
  logic [VAL_W-1:0]     val1_q, val1_d;
  logic [VAL_W-1:0]     val2_q, val2_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic [NUM_TILES-1:0] matched_q, matched_d;
  logic [NUM_TILES-1:0] shown_q, shown_d;  // currently selected, not yet matched
  logic [ADDR_W-1:0]    pairs_q, pairs_d;
  logic [7:0]           moves_q, moves_d;

  logic key_up, key_down, key_left, key_right, key_select;
  logic [ADDR_W-1:0] cursor_idx;
  logic sel1_ok, sel2_ok, vals_equal, last_pair, move_en;

  ps2_key_decoder u_key_decoder (
    .CLOCK_50       (CLOCK_50),
    .userquit       (userquit),
    .clear          (!ingameOn),
    .ps2_key_data   (ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed),
    .up             (key_up),
    .down           (key_down),
    .left           (key_left),
    .right          (key_right),
    .select         (key_select)
  );

  always_comb begin
    cursor_idx = ADDR_W'(row_q) * ADDR_W'(GRID_W) + ADDR_W'(col_q);
    sel1_ok    = key_select && !matched_q[cursor_idx];
    sel2_ok    = key_select && !matched_q[cursor_idx] && (cursor_idx != sel1_q);
    vals_equal = (val1_q == val2_q);
    last_pair  = ((pairs_q + 1'b1) == ADDR_W'(NUM_TILES / 2));
    move_en    = (state_q == StSel1) || (state_q == StSel2);
  end

  // State register
  always_ff @(posedge CLOCK_50 or posedge userquit) begin
    if (userquit) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge CLOCK_50 or posedge userquit) begin
    if (userquit) begin
      row_q     <= '0;
      col_q     <= '0;
      sel1_q    <= '0;
      sel2_q    <= '0;
      val1_q    <= '0;
      val2_q    <= '0;
      timer_q   <= '0;
      matched_q <= '0;
      shown_q   <= '0;
      pairs_q   <= '0;
      moves_q   <= '0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      sel1_q    <= sel1_d;
      sel2_q    <= sel2_d;
      val1_q    <= val1_d;
      val2_q    <= val2_d;
      timer_q   <= timer_d;
      matched_q <= matched_d;
      shown_q   <= shown_d;
      pairs_q   <= pairs_d;
      moves_q   <= moves_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!ingameOn) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StSel1;
        StSel1: if (sel1_ok) state_d = StRd1;
        StRd1:  state_d = StCap1;
        StCap1: state_d = StSel2;
        StSel2: if (sel2_ok) state_d = StRd2;
        StRd2:  state_d = StCap2;
        StCap2: state_d = StCmp;
        StCmp: begin
          if (vals_equal) state_d = last_pair ? StDone : StSel1;
          else            state_d = StShow;
        end
        StShow: if (timer_q == '0) state_d = StSel1;
        StDone: state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath next-state
  always_comb begin
    row_d     = row_q;
    col_d     = col_q;
    sel1_d    = sel1_q;
    sel2_d    = sel2_q;
    val1_d    = val1_q;
    val2_d    = val2_q;
    timer_d   = timer_q;
    matched_d = matched_q;
    shown_d   = shown_q;
    pairs_d   = pairs_q;
    moves_d   = moves_q;

    if (!ingameOn) begin
      row_d     = '0;
      col_d     = '0;
      sel1_d    = '0;
      sel2_d    = '0;
      val1_d    = '0;
      val2_d    = '0;
      timer_d   = '0;
      matched_d = '0;
      shown_d   = '0;
      pairs_d   = '0;
      moves_d   = '0;
    end else begin
      if (move_en) begin
        // Clamp at the grid edges.
        if (key_up && (row_q != '0))                      row_d = row_q - 1'b1;
        if (key_down && (row_q != RowW'(GRID_H - 1)))     row_d = row_q + 1'b1;
        if (key_left && (col_q != '0))                    col_d = col_q - 1'b1;
        if (key_right && (col_q != ColW'(GRID_W - 1)))    col_d = col_q + 1'b1;
      end

      unique case (state_q)
        StSel1: if (sel1_ok) sel1_d = cursor_idx;
        StSel2: if (sel2_ok) sel2_d = cursor_idx;
        StCap1: begin
          val1_d          = tile_val;
          shown_d[sel1_q] = 1'b1;
        end
        StCap2: begin
          val2_d          = tile_val;
          shown_d[sel2_q] = 1'b1;
          if (moves_q != 8'hFF) moves_d = moves_q + 8'd1;
        end
        StCmp: begin
          if (vals_equal) begin
            matched_d[sel1_q] = 1'b1;
            matched_d[sel2_q] = 1'b1;
            shown_d           = '0;
            pairs_d           = pairs_q + 1'b1;
          end else begin
            timer_d = TimerW'(SHOW_CYCLES - 1);
          end
        end
        StShow: begin
          if (timer_q == '0) shown_d = '0;
          else               timer_d = timer_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    tile_rd     = (state_q == StRd1) || (state_q == StRd2);
    tile_addr   = '0;
    if (state_q == StRd1) tile_addr = sel1_q;
    if (state_q == StRd2) tile_addr = sel2_q;
    cursor      = cursor_idx;
    face_up     = matched_q | shown_q;
    pairs_found = pairs_q;
    moves       = moves_q;
    gameOver    = (state_q == StDone);
  end

endmodule

// File: tb/tb_ingame_turn_fsm.sv
module tb_ingame_turn_fsm;
  import game_pkg::*;

  logic        CLOCK_50 = 1'b0;
  logic        userquit;
  logic        ingameOn;
  logic [7:0]  ps2_key_data;
  logic        ps2_key_pressed;
  logic [3:0]  tile_addr;
  logic        tile_rd;
  logic [2:0]  tile_val = '0;
  logic [3:0]  cursor;
  logic [15:0] face_up;
  logic [3:0]  pairs_found;
  logic [7:0]  moves;
  logic        gameOver;

  ingame_turn_fsm #(
    .SHOW_CYCLES(4)
  ) dut (
    .CLOCK_50       (CLOCK_50),
    .userquit       (userquit),
    .ingameOn       (ingameOn),
    .ps2_key_data   (ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed),
    .tile_addr      (tile_addr),
    .tile_rd        (tile_rd),
    .tile_val       (tile_val),
    .cursor         (cursor),
    .face_up        (face_up),
    .pairs_found    (pairs_found),
    .moves          (moves),
    .gameOver       (gameOver)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Board memory model: one-cycle read latency.
  logic [2:0] mem [16];
  always @(posedge CLOCK_50) if (tile_rd) tile_val <= mem[tile_addr];

  typedef struct {
    string       name;
    logic [3:0]  cur;
    logic [15:0] face;
    logic [3:0]  pairs;
    logic [7:0]  mv;
    logic        go;
  } snap_t;

  snap_t      exp_q[$];
  logic [3:0] rd_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         finishing = 1'b0;
  event       sample_ev;
  int         br = 0, bc = 0;  // bench's own cursor row/column

  function automatic void expect_snap(input string n, input logic [3:0] c,
                                      input logic [15:0] f, input logic [3:0] p,
                                      input logic [7:0] m, input logic g);
    snap_t s;
    s.name = n; s.cur = c; s.face = f; s.pairs = p; s.mv = m; s.go = g;
    exp_q.push_back(s);
  endfunction

  // Monitor: every read strobe must match an expected read; snapshots are
  // compared as soon as they are queued (next negedge or on demand).
  snap_t      e;
  logic [3:0] exp_a;
  always @(negedge CLOCK_50 or sample_ev) begin
    if (tile_rd) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd: tile_rd=1 tile_addr=%0d, required no read", tile_addr);
      end else begin
        exp_a = rd_q.pop_front();
        if (tile_addr !== exp_a) begin
          errors++;
          $display("FAIL rd_addr: tile_addr=%0d, required %0d", tile_addr, exp_a);
        end
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({cursor, face_up, pairs_found, moves, gameOver} !==
          {e.cur, e.face, e.pairs, e.mv, e.go}) begin
        errors++;
        $display("FAIL %s: cursor=%0d face_up=%h pairs=%0d moves=%0d gameOver=%b, required cursor=%0d face_up=%h pairs=%0d moves=%0d gameOver=%b",
                 e.name, cursor, face_up, pairs_found, moves, gameOver,
                 e.cur, e.face, e.pairs, e.mv, e.go);
      end
    end
    if (finishing) begin
      checks++;
      if (rd_q.size() != 0) begin
        errors++;
        $display("FAIL missing_rd: %0d expected reads never seen, required 0", rd_q.size());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic key(input logic [7:0] b);
    @(posedge CLOCK_50); #1;
    ps2_key_data    = b;
    ps2_key_pressed = 1'b1;
    @(posedge CLOCK_50); #1;
    ps2_key_pressed = 1'b0;
  endtask

  task automatic move_to(input int t);
    while (br < t / 4) begin key(KeyDown);  br++; end
    while (br > t / 4) begin key(KeyUp);    br--; end
    while (bc < t % 4) begin key(KeyRight); bc++; end
    while (bc > t % 4) begin key(KeyLeft);  bc--; end
  endtask

  task automatic select_tile(input logic [3:0] a);
    rd_q.push_back(a);
    key(KeySelect);
    tick(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    userquit = 1'b1; ingameOn = 1'b0; ps2_key_data = '0; ps2_key_pressed = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 3'd7;
    mem[0] = 3'd2; mem[1] = 3'd2; mem[4] = 3'd2; mem[5] = 3'd5;
    tick(3);
    userquit = 1'b0;
    expect_snap("reset", 4'd0, 16'h0, 4'd0, 8'd0, 1'b0);
    tick(1);

    // Clamping
    ingameOn = 1'b1;
    tick(1);
    key(KeyLeft); key(KeyUp);
    expect_snap("clamp_ul", 4'd0, 16'h0, 4'd0, 8'd0, 1'b0);
    repeat (5) key(KeyRight);
    expect_snap("clamp_right", 4'd3, 16'h0, 4'd0, 8'd0, 1'b0);
    repeat (5) key(KeyDown);
    expect_snap("clamp_down", 4'd15, 16'h0, 4'd0, 8'd0, 1'b0);
    br = 3; bc = 3;

    // Break filter
    repeat (3) key(KeyLeft);
    bc = 0;
    key(KeyBreak); key(KeyRight);
    expect_snap("break_drop", 4'd12, 16'h0, 4'd0, 8'd0, 1'b0);
    key(KeyRight);
    bc = 1;
    expect_snap("after_break", 4'd13, 16'h0, 4'd0, 8'd0, 1'b0);

    // ingameOn falls with a coincident key strobe
    ingameOn = 1'b0; ps2_key_data = KeyRight; ps2_key_pressed = 1'b1;
    tick(1);
    ps2_key_pressed = 1'b0;
    br = 0; bc = 0;
    expect_snap("off_clear", 4'd0, 16'h0, 4'd0, 8'd0, 1'b0);

    // Match on tiles 0 and 1
    ingameOn = 1'b1;
    tick(1);
    select_tile(4'd0);
    expect_snap("m_first", 4'd0, 16'h0001, 4'd0, 8'd0, 1'b0);
    move_to(1);
    rd_q.push_back(4'd1);
    key(KeySelect);
    tick(3);
    expect_snap("m_match", 4'd1, 16'h0003, 4'd1, 8'd1, 1'b0);
    move_to(0);
    key(KeySelect);  // matched tile: no read expected
    tick(3);
    expect_snap("m_reselect", 4'd0, 16'h0003, 4'd1, 8'd1, 1'b0);

    // Mismatch on tiles 4 and 5
    ingameOn = 1'b0;
    tick(1);
    br = 0; bc = 0;
    expect_snap("off2", 4'd0, 16'h0, 4'd0, 8'd0, 1'b0);
    ingameOn = 1'b1;
    tick(1);
    move_to(4);
    select_tile(4'd4);
    expect_snap("mm_first", 4'd4, 16'h0010, 4'd0, 8'd0, 1'b0);
    key(KeySelect);  // same tile: no second read
    tick(2);
    expect_snap("mm_same", 4'd4, 16'h0010, 4'd0, 8'd0, 1'b0);
    move_to(5);
    rd_q.push_back(4'd5);
    key(KeySelect);
    tick(2);
    expect_snap("mm_cap2", 4'd5, 16'h0030, 4'd0, 8'd1, 1'b0);
    key(KeyLeft);    // lands in SHOW: ignored
    expect_snap("mm_show", 4'd5, 16'h0030, 4'd0, 8'd1, 1'b0);
    tick(2);
    expect_snap("mm_hold", 4'd5, 16'h0030, 4'd0, 8'd1, 1'b0);
    tick(1);
    expect_snap("mm_clear", 4'd5, 16'h0000, 4'd0, 8'd1, 1'b0);
    move_to(4);
    expect_snap("mm_sel1", 4'd4, 16'h0000, 4'd0, 8'd1, 1'b0);
    select_tile(4'd4);
    expect_snap("mm_resel", 4'd4, 16'h0010, 4'd0, 8'd1, 1'b0);

    // userquit during SHOW
    move_to(5);
    rd_q.push_back(4'd5);
    key(KeySelect);
    tick(4);
    expect_snap("pre_quit", 4'd5, 16'h0030, 4'd0, 8'd2, 1'b0);
    @(negedge CLOCK_50); #1;
    userquit = 1'b1;
    #1;
    expect_snap("quit_async", 4'd0, 16'h0, 4'd0, 8'd0, 1'b0);
    -> sample_ev;
    tick(1);
    userquit = 1'b0;
    br = 0; bc = 0;
    tick(1);

    // Full game: tiles 2p and 2p+1 share value p
    for (int i = 0; i < 16; i++) mem[i] = 3'(i / 2);
    for (int p = 0; p < 8; p++) begin
      move_to(2 * p);
      select_tile(4'(2 * p));
      move_to(2 * p + 1);
      rd_q.push_back(4'(2 * p + 1));
      key(KeySelect);
      if (p < 7) begin
        tick(3);
        expect_snap("g_pair", 4'(2 * p + 1), 16'((32'd1 << (2 * p + 2)) - 1),
                    4'(p + 1), 8'(p + 1), 1'b0);
      end else begin
        tick(2);
        expect_snap("g_pre_done", 4'd15, 16'hFFFF, 4'd7, 8'd8, 1'b0);
        tick(1);
        expect_snap("g_done", 4'd15, 16'hFFFF, 4'd8, 8'd8, 1'b1);
      end
    end
    key(KeyLeft);    // DONE ignores keys
    expect_snap("done_key", 4'd15, 16'hFFFF, 4'd8, 8'd8, 1'b1);
    ingameOn = 1'b0;
    tick(1);
    expect_snap("done_off", 4'd0, 16'h0, 4'd0, 8'd0, 1'b0);
    tick(2);

    finishing = 1'b1;
    -> sample_ev;
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
